// File: rtl/audio_echo_delay_core.sv
// audio_echo_delay_core
//   Multi-channel feedback echo on parallel PCM frames in the clk256 domain.
//   Each accepted frame is processed one channel at a time:
//     y[n] = x[n] + (y[n-D] >>> mix_shift)
//   The result (or x itself when bypassed) goes to the output frame and back
//   into the delay line. After every reset release the delay RAM is swept to
//   zero before the first frame is accepted.
//
//   Build option: define ECHO_SATURATE_EN to clamp the mix sum to the signed
//   audio_width range. Without it the sum wraps (two's complement).
//
// Ports
//   clk256     : single clock, rising edge
//   reset      : asynchronous, active-high; aborts any frame in progress
//   in_valid   : input frame valid
//   in_ready   : core idle and able to accept a frame
//   in_data    : input frame, channel 0 in the LSBs
//   delay_len  : delay D in frames, 0 selects delay_samples
//   bypass     : output equals input; delay line still written with x
//   out_valid  : one-cycle strobe marking a new out_data
//   out_data   : processed frame, held until the next out_valid
module audio_echo_delay_core #(
  parameter int audio_width   = 16,
  parameter int delay_samples = 2048,
  parameter int channels      = 2,
  parameter int mix_shift     = 1
) (
  input  logic                              clk256,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [channels*audio_width-1:0]   in_data,
  input  logic [$clog2(delay_samples)-1:0]  delay_len,
  input  logic                              bypass,
  output logic                              out_valid,
  output logic [channels*audio_width-1:0]   out_data
);

  localparam int ptr_w  = $clog2(delay_samples);
  localparam int ch_w   = (channels > 1) ? $clog2(channels) : 1;
  localparam int words  = delay_samples * channels;
  localparam int addr_w = $clog2(words);
  localparam int fw     = channels * audio_width;

  localparam logic [2:0] st_clear = 3'd0;
  localparam logic [2:0] st_idle  = 3'd1;
  localparam logic [2:0] st_read  = 3'd2;
  localparam logic [2:0] st_mix   = 3'd3;
  localparam logic [2:0] st_done  = 3'd4;

  logic [2:0]             state;
  logic [ptr_w-1:0]       wr_ptr;
  logic [ch_w-1:0]        ch;
  logic [addr_w-1:0]      clear_cnt;
  logic [fw-1:0]          x_reg;
  logic [ptr_w-1:0]       dl_reg;
  logic                   byp_reg;
  logic [fw-1:0]          y_buf;

  logic                   ram_we;
  logic [addr_w-1:0]      ram_addr;
  logic [audio_width-1:0] ram_wdata;
  logic [audio_width-1:0] rd_data;
  logic [audio_width-1:0] mem [words];

  logic [ptr_w-1:0]       rd_ptr;
  logic signed [audio_width-1:0] x_s;
  logic signed [audio_width-1:0] d_s;
  logic signed [audio_width-1:0] y;
  logic [audio_width-1:0] mix_out;
  logic [fw-1:0]          frame_next;

  assign in_ready  = (state == st_idle);
  assign out_valid = (state == st_done);

  // Delay line is a power of two, so modular subtraction is plain wrap.
  // delay_len 0 lands on wr_ptr itself: the oldest frame, delay_samples ago.
  assign rd_ptr = wr_ptr - dl_reg;

  assign x_s = x_reg[ch*audio_width +: audio_width];
  assign d_s = rd_data;

`ifdef ECHO_SATURATE_EN
  logic signed [audio_width:0] sum;
  always_comb begin
    sum = $signed({x_s[audio_width-1], x_s}) +
          ($signed({d_s[audio_width-1], d_s}) >>> mix_shift);
    // Sign bits disagree only when the sum left the audio_width range.
    if (sum[audio_width] != sum[audio_width-1])
      y = sum[audio_width] ? {1'b1, {(audio_width-1){1'b0}}}
                           : {1'b0, {(audio_width-1){1'b1}}};
    else
      y = sum[audio_width-1:0];
  end
`else
  // Wrapping result is identical to truncating the audio_width+1 bit sum.
  assign y = x_s + (d_s >>> mix_shift);
`endif

  assign mix_out = byp_reg ? x_s : y;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    ram_we     = 1'b0;
    ram_addr   = clear_cnt;
    ram_wdata  = '0;
    frame_next = y_buf;
    frame_next[ch*audio_width +: audio_width] = mix_out;
    case (state)
      st_clear: ram_we = 1'b1;
      st_read:  ram_addr = addr_w'(rd_ptr) * addr_w'(channels) + addr_w'(ch);
      st_mix: begin
        ram_we    = 1'b1;
        ram_addr  = addr_w'(wr_ptr) * addr_w'(channels) + addr_w'(ch);
        ram_wdata = mix_out;
      end
      default: ;
    endcase
  end

  // NOTE: the delay RAM has no reset; its contents are zeroed by the clear
  // sweep instead, which lets it map onto block RAM.
  always_ff @(posedge clk256) begin
    if (ram_we)
      mem[ram_addr] <= ram_wdata;
    rd_data <= mem[ram_addr];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk256 or posedge reset) begin
    if (reset) begin
      state     <= st_clear;
      wr_ptr    <= '0;
      ch        <= '0;
      clear_cnt <= '0;
      x_reg     <= '0;
      dl_reg    <= '0;
      byp_reg   <= 1'b0;
      y_buf     <= '0;
      out_data  <= '0;
    end else begin
      case (state)
        st_clear: begin
          if (clear_cnt == addr_w'(words - 1)) begin
            clear_cnt <= '0;
            state     <= st_idle;
          end else begin
            clear_cnt <= clear_cnt + addr_w'(1);
          end
        end
        st_idle: begin
          if (in_valid) begin
            x_reg   <= in_data;
            dl_reg  <= delay_len;
            byp_reg <= bypass;
            ch      <= '0;
            state   <= st_read;
          end
        end
        st_read: state <= st_mix;
        st_mix: begin
          y_buf <= frame_next;
          if (ch == ch_w'(channels - 1)) begin
            // Publish the whole frame at once so out_data never shows a
            // half-updated frame between strobes.
            out_data <= frame_next;
            state    <= st_done;
          end else begin
            ch    <= ch + ch_w'(1);
            state <= st_read;
          end
        end
        st_done: begin
          wr_ptr <= wr_ptr + ptr_w'(1);
          state  <= st_idle;
        end
        default: state <= st_clear;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_echo_delay_core.sv
// Testbench for audio_echo_delay_core (16-bit, 8-deep, stereo, mix_shift 1).
// Stimulus pushes expected frames into a queue; a monitor on the falling
// edge pops and compares whenever out_valid is seen.
module tb_audio_echo_delay_core;

  localparam int W  = 16;
  localparam int DS = 8;
  localparam int CH = 2;
  localparam int MS = 1;
  localparam int PW = $clog2(DS);
  localparam int FW = CH * W;

  logic          clk256 = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FW-1:0] in_data = '0;
  logic [PW-1:0] delay_len = '0;
  logic          bypass = 1'b0;
  logic          out_valid;
  logic [FW-1:0] out_data;

  audio_echo_delay_core #(
    .audio_width(W), .delay_samples(DS), .channels(CH), .mix_shift(MS)
  ) dut (
    .clk256(clk256), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .delay_len(delay_len), .bypass(bypass),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk256 = ~clk256;

  int cyc = 0;
  always @(posedge clk256) cyc <= cyc + 1;

  typedef struct {
    logic [FW-1:0] data;
    int            acc;
  } exp_t;

  exp_t          q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [FW-1:0] last_exp = '0;
  bit            prev_ov = 1'b0;
  int            last_acc = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: delay line of past outputs per channel, indexed by frame.
  int mm[DS][CH];
  int mptr = 0;

  task automatic model_reset();
    for (int f = 0; f < DS; f++)
      for (int c = 0; c < CH; c++)
        mm[f][c] = 0;
    mptr = 0;
  endtask

  task automatic model_frame(input logic [FW-1:0] x, input int dl,
                             input bit byp, output logic [FW-1:0] o);
    int d_frames, rp, xi, s, y, r;
    logic signed [W-1:0] t;
    d_frames = (dl == 0) ? DS : dl;
    rp = (mptr - d_frames + DS) % DS;
    o = '0;
    for (int c = 0; c < CH; c++) begin
      t  = x[c*W +: W];
      xi = t;
      s  = xi + (mm[rp][c] >>> MS);
`ifdef ECHO_SATURATE_EN
      if (s > 32767) y = 32767;
      else if (s < -32768) y = -32768;
      else y = s;
`else
      t = s[W-1:0];
      y = t;
`endif
      r = byp ? xi : y;
      mm[mptr][c] = r;
      o[c*W +: W] = r[W-1:0];
    end
    mptr = (mptr + 1) % DS;
  endtask

  // Monitor
  always @(negedge clk256) begin
    if (reset) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      last_exp = '0;
      prev_ov  = 1'b0;
    end else begin
      if (out_valid) begin
        check("out_valid_single", prev_ov, 0);
        check("in_ready_low_at_out", in_ready, 0);
        if (q.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          for (int c = 0; c < CH; c++)
            check($sformatf("lane%0d", c), out_data[c*W +: W], e.data[c*W +: W]);
          check("out_latency", cyc - e.acc, 2 * CH);
          last_exp = e.data;
        end
      end else begin
        check("out_data_held", out_data, last_exp);
      end
      prev_ov = out_valid;
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [FW-1:0] x, input int dl, input bit byp,
                      input bit hold);
    int t;
    bit acc;
    logic [FW-1:0] o;
    t = 0;
    acc = 1'b0;
    in_data   = x;
    delay_len = dl[PW-1:0];
    bypass    = byp;
    in_valid  = 1'b1;
    while (!acc && t < 200) begin
      if (in_ready) acc = 1'b1;
      @(posedge clk256);
      @(negedge clk256);
      t++;
    end
    if (acc) begin
      model_frame(x, dl, byp, o);
      q.push_back('{data: o, acc: cyc});
      last_acc = cyc;
    end else begin
      check("accept_timeout", in_ready, 1);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic do_reset(input int hold_cycles);
    int n;
    #1 reset = 1'b1;
    in_valid = 1'b0;
    q.delete();
    repeat (hold_cycles) @(negedge clk256);
    #1 reset = 1'b0;
    model_reset();
    n = 0;
    do begin
      @(posedge clk256);
      #1;
      n++;
    end while (!in_ready && n < 100);
    check("clear_len", n, DS * CH);
    @(negedge clk256);
  endtask

  function automatic logic [FW-1:0] fr(input logic [W-1:0] c0,
                                       input logic [W-1:0] c1);
    return {c1, c0};
  endfunction

  initial begin
    int a, t;
    @(negedge clk256);
    do_reset(3);

    // Impulse, D = 3
    for (int i = 0; i < 9; i++)
      send(fr((i == 0) ? 16'h4000 : 16'h0000, 16'h0000), 3, 1'b0, 1'b0);

    // Back-to-back with in_valid held high
    send(fr(16'h1234, 16'hFEDC), 2, 1'b0, 1'b1);
    a = last_acc;
    send(fr(16'h8000, 16'h7FFF), 5, 1'b0, 1'b0);
    check("b2b_spacing", last_acc - a, 2 * CH + 2);

    // Overflow, D = 1
    do_reset(2);
    for (int i = 0; i < 4; i++)
      send(fr(16'h7000, 16'h9000), 1, 1'b0, 1'b0);

    // delay_len = 0 across the pointer wrap, then bypass, then echoes resume
    do_reset(2);
    for (int i = 0; i < 11; i++)
      send(fr((i == 0) ? 16'h4000 : 16'h0000, 16'h0000), 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      send(FW'($urandom), 0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++)
      send(fr(16'h0000, 16'h0000), 0, 1'b0, 1'b0);

    // Abort during READ of ch1, then check the line was re-cleared
    for (int i = 0; i < 10; i++)
      send(FW'($urandom), $urandom_range(0, DS - 1), 1'b0, 1'b0);
    send(fr(16'h1111, 16'h2222), 3, 1'b0, 1'b0);
    @(posedge clk256);
    @(posedge clk256);
    @(negedge clk256);
    do_reset(2);
    for (int i = 0; i < 10; i++)
      send(fr((i == 0) ? 16'h4000 : 16'h0000, 16'h0000), 3, 1'b0, 1'b0);

    // Random traffic with idle gaps and input churn while not valid
    for (int i = 0; i < 120; i++) begin
      send(FW'($urandom), $urandom_range(0, DS - 1),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 3)) begin
        if (!in_valid) begin
          in_data   = FW'($urandom);
          delay_len = PW'($urandom);
          bypass    = $urandom_range(0, 1) == 1;
        end
        @(negedge clk256);
      end
    end
    in_valid = 1'b0;

    t = 0;
    while (q.size() > 0 && t < 100) begin
      @(negedge clk256);
      t++;
    end
    check("drain", q.size(), 0);
    repeat (3) @(negedge clk256);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
